// File: rtl/mercury2_dac_scheduler_pkg.sv
// Shared types and constants for the Mercury2 DAC scheduler (package merc2_dac_pkg).
package merc2_dac_pkg;

  localparam int DAC_DATA_W = 10;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    SETTLE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mercury2_dac_scheduler_if.sv
// Requester write port bundle: one requester feeding one pending buffer.
// Handshake: wr is a one-cycle load strobe with din valid alongside it; there is no ready,
// the buffer always accepts, and pend reports that an unissued value is held.
interface mercury2_dac_scheduler_if;
  import merc2_dac_pkg::*;

  logic                  wr;
  logic [DAC_DATA_W-1:0] din;
  logic                  pend;

  modport master (output wr, output din, input pend);
  modport slave  (input wr, input din, output pend);

endinterface

// File: rtl/mercury2_dac_scheduler_pend_buf.sv
// Single-channel pending value register with load / issue / overflow handling.
// MERC2_DAC_SCHED_COALESCE_EN: a write onto a held value replaces it instead of being dropped.
module dac_pend_buf
  import merc2_dac_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  mercury2_dac_scheduler_if.slave wr_if,
  input  logic                    issue,
  output logic [DAC_DATA_W-1:0]   value,
  output logic                    overflow
);

  logic                  pend_q, pend_d;
  logic [DAC_DATA_W-1:0] value_q, value_d;

  always_comb begin
    pend_d   = pend_q;
    value_d  = value_q;
    overflow = 1'b0;
    if (issue) pend_d = 1'b0;
    if (wr_if.wr) begin
      // The slot is free if empty or being drained this very cycle.
      if (!pend_q || issue) begin
        value_d = wr_if.din;
        pend_d  = 1'b1;
      end else begin
`ifdef MERC2_DAC_SCHED_COALESCE_EN
        value_d = wr_if.din;
`else
        overflow = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= 1'b0;
      value_q <= '0;
    end else begin
      pend_q  <= pend_d;
      value_q <= value_d;
    end
  end

  assign wr_if.pend = pend_q;
  assign value      = value_q;

endmodule

// File: rtl/mercury2_dac_scheduler.sv
// Round-robin sharing of the two-channel Mercury2 DAC wrapper between requesters A and B.
// Optional MERC2_DAC_SCHED_COALESCE_EN selects latest-wins pending writes (see dac_pend_buf).
module mercury2_dac_scheduler
  import merc2_dac_pkg::*;
#(
  parameter int BusyStartTimeout = 8,
  parameter int TimeoutWidth     = 4
) (
  input  logic                  clk_50MHZ,
  input  logic                  reset,
  input  logic                  wr_a,
  input  logic [DAC_DATA_W-1:0] din_a,
  input  logic                  wr_b,
  input  logic [DAC_DATA_W-1:0] din_b,
  input  logic                  clear_err,
  output logic                  pend_a,
  output logic                  pend_b,
  output logic                  dac_trigger,
  output logic                  dac_channel,
  output logic [DAC_DATA_W-1:0] dac_din,
  input  logic                  dac_busy,
  output logic                  done,
  output logic                  done_channel,
  output logic                  overflow_err,
  output logic                  timeout_err
);

  localparam logic [TimeoutWidth-1:0] CNT_LAST = TimeoutWidth'(BusyStartTimeout - 1);

  mercury2_dac_scheduler_if buf_a_if ();
  mercury2_dac_scheduler_if buf_b_if ();

  logic [DAC_DATA_W-1:0] val_a, val_b;
  logic                  ov_a, ov_b;
  logic                  issue_a, issue_b, sel_b, timeout_ev;

  assign buf_a_if.wr  = wr_a;
  assign buf_a_if.din = din_a;
  assign buf_b_if.wr  = wr_b;
  assign buf_b_if.din = din_b;
  assign pend_a       = buf_a_if.pend;
  assign pend_b       = buf_b_if.pend;

  dac_pend_buf u_buf_a (
    .clk(clk_50MHZ), .reset(reset), .wr_if(buf_a_if.slave),
    .issue(issue_a), .value(val_a), .overflow(ov_a)
  );

  dac_pend_buf u_buf_b (
    .clk(clk_50MHZ), .reset(reset), .wr_if(buf_b_if.slave),
    .issue(issue_b), .value(val_b), .overflow(ov_b)
  );

  sched_state_e          state_q, state_d;
  logic                  last_q, last_d;
  logic                  trig_q, trig_d;
  logic                  ch_q, ch_d;
  logic [DAC_DATA_W-1:0] din_q, din_d;
  logic                  done_q, done_d;
  logic                  done_ch_q, done_ch_d;
  logic [TimeoutWidth-1:0] cnt_q, cnt_d;
  logic                  ovf_err_q, ovf_err_d;
  logic                  to_err_q, to_err_d;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    trig_d     = 1'b0;
    ch_d       = ch_q;
    din_d      = din_q;
    done_d     = 1'b0;
    done_ch_d  = done_ch_q;
    cnt_d      = cnt_q;
    issue_a    = 1'b0;
    issue_b    = 1'b0;
    sel_b      = 1'b0;
    timeout_ev = 1'b0;
    case (state_q)
      IDLE: begin
        // A Busy still high from any source holds off the next issue.
        if (!dac_busy && (pend_a || pend_b)) begin
          sel_b   = (pend_a && pend_b) ? (last_q == CH_A) : pend_b;
          ch_d    = sel_b ? CH_B : CH_A;
          din_d   = sel_b ? val_b : val_a;
          issue_a = !sel_b;
          issue_b = sel_b;
          last_d  = ch_d;
          cnt_d   = '0;
          trig_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (dac_busy) begin
          state_d = SETTLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_ev = 1'b1;
          done_d     = 1'b1;
          done_ch_d  = ch_q;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (!dac_busy) begin
          done_d    = 1'b1;
          done_ch_d = ch_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new error event outranks a simultaneous clear.
    ovf_err_d = (ov_a | ov_b) | (ovf_err_q & ~clear_err);
    to_err_d  = timeout_ev | (to_err_q & ~clear_err);
  end

  always_ff @(posedge clk_50MHZ) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= CH_B;
      trig_q    <= 1'b0;
      ch_q      <= CH_A;
      din_q     <= '0;
      done_q    <= 1'b0;
      done_ch_q <= 1'b0;
      cnt_q     <= '0;
      ovf_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      trig_q    <= trig_d;
      ch_q      <= ch_d;
      din_q     <= din_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
      cnt_q     <= cnt_d;
      ovf_err_q <= ovf_err_d;
      to_err_q  <= to_err_d;
    end
  end

  assign dac_trigger  = trig_q;
  assign dac_channel  = ch_q;
  assign dac_din      = din_q;
  assign done         = done_q;
  assign done_channel = done_ch_q;
  assign overflow_err = ovf_err_q;
  assign timeout_err  = to_err_q;

endmodule
